otter_timer_bank: RTL and testbench

Memory-mapped bank of `NUM_CH` independent down-counting timers on the OTTER I/O bus. It generalises the single-channel timer-counter with per-channel prescaler, periodic or one-shot mode, per-channel interrupt enable, and a write-1-to-clear pending register. The bank drives one level interrupt into the MCU `intr` input. It sits beside the output-port registers in the wrapper and shares the wrapper's `iobus_*` signals and divided clock.

---
 rtl/otter_tmr_pkg.sv | 14 +
 rtl/tmr_channel.sv | 77 +++++++
 rtl/otter_timer_bank.sv | 56 +++++
 tb/tb_otter_timer_bank.sv | 121 ++++++++++++
 4 files changed

// File: rtl/otter_tmr_pkg.sv
// otter_tmr_pkg: shared register map, CSR bit layout and mode type for the timer bank
package otter_tmr_pkg;
  localparam logic [3:0] CSR_OFF = 4'h0;
  localparam logic [3:0] LOAD_OFF = 4'h4;
  localparam logic [3:0] COUNT_OFF = 4'h8;
  localparam logic [8:0] PEND_OFF = 9'h100;
  localparam int CH_STRIDE = 16;
  localparam int EN_BIT = 0;
  localparam int MODE_BIT = 1;
  localparam int IE_BIT = 2;
  localparam int PRE_LSB = 8;
  localparam int PRE_MSB = 15;
  typedef enum logic {PERIODIC = 1'b0, ONESHOT = 1'b1} tmr_mode_t;
endpackage

// File: rtl/tmr_channel.sv
// tmr_channel: one down-counting timer with prescaler, periodic/one-shot mode and terminal event
module tmr_channel
  import otter_tmr_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_we,
  input  logic             load_we,
  input  logic [31:0]      wdata,
  output logic [31:0]      csr,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] count,
  output logic             tc_evt
);
  logic en_q, en_d, ie_q, ie_d;
  tmr_mode_t mode_q, mode_d;
  logic [7:0] pre_q, pre_d, ps_q, ps_d;
  logic [CNT_W-1:0] load_q, load_d, count_q, count_d;
  logic tick, zero, stop_wr;
  assign tick = en_q && ps_q == pre_q;
  assign zero = count_q == '0;
  assign stop_wr = csr_we && !wdata[EN_BIT];
  // a register write in the same cycle overrides the tick, so it cannot raise pending
  assign tc_evt = tick && zero && !load_we && !stop_wr;
  assign csr = {16'b0, pre_q, 5'b0, ie_q, 1'(mode_q), en_q};
  assign load = load_q;
  assign count = count_q;
  // tick processing first, then bus writes take priority over it
  always_comb begin
    en_d = en_q;
    mode_d = mode_q;
    ie_d = ie_q;
    pre_d = pre_q;
    load_d = load_q;
    count_d = count_q;
    ps_d = en_q ? (tick ? 8'd0 : ps_q + 8'd1) : ps_q;
    if (tick) begin
      count_d = !zero ? count_q - CNT_W'(1) : (mode_q == PERIODIC ? load_q : '0);
      en_d = !(zero && mode_q == ONESHOT);
    end
    if (csr_we) begin
      en_d = wdata[EN_BIT];
      mode_d = tmr_mode_t'(wdata[MODE_BIT]);
      ie_d = wdata[IE_BIT];
      pre_d = wdata[PRE_MSB:PRE_LSB];
      count_d = !wdata[EN_BIT] ? count_q : (!en_q ? load_q : count_d);
      ps_d = !wdata[EN_BIT] ? ps_q : (!en_q ? 8'd0 : ps_d);
    end
    if (load_we) begin
      load_d = wdata[CNT_W-1:0];
      count_d = wdata[CNT_W-1:0];
      ps_d = 8'd0;
    end
  end
  // channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
      mode_q <= PERIODIC;
      ie_q <= 1'b0;
      pre_q <= '0;
      ps_q <= '0;
      load_q <= '0;
      count_q <= '0;
    end else begin
      en_q <= en_d;
      mode_q <= mode_d;
      ie_q <= ie_d;
      pre_q <= pre_d;
      ps_q <= ps_d;
      load_q <= load_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/otter_timer_bank.sv
// otter_timer_bank: bus decode, read mux, pending register and interrupt for NUM_CH timers
module otter_timer_bank
  import otter_tmr_pkg::*;
#(
  parameter int          NUM_CH = 4,
  parameter int          CNT_W = 32,
  parameter logic [31:0] BASE_ADDR = 32'h1100_D000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] iobus_in,
  output logic        intr
);
  logic in_bank, pend_hit;
  logic [8:0] off;
  logic [3:0] rsel;
  logic [NUM_CH-1:0] pend_q, pend_d, tc, ie;
  logic [NUM_CH-1:0][31:0] ch_rd;
  assign off = iobus_addr[8:0];
  assign rsel = off[3:0];
  assign in_bank = iobus_addr[31:9] == BASE_ADDR[31:9];
  assign pend_hit = in_bank && off == PEND_OFF;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic ch_hit;
    logic [31:0] csr_v;
    logic [CNT_W-1:0] load_v, count_v;
    assign ch_hit = in_bank && off[8:4] == 5'(k * CH_STRIDE / 16);
    assign ie[k] = csr_v[IE_BIT];
    assign ch_rd[k] = !ch_hit ? '0 : rsel == CSR_OFF ? csr_v : rsel == LOAD_OFF ? 32'(load_v) :
                      rsel == COUNT_OFF ? 32'(count_v) : '0;
    tmr_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst(RST),
      .csr_we(iobus_wr && ch_hit && rsel == CSR_OFF),
      .load_we(iobus_wr && ch_hit && rsel == LOAD_OFF),
      .wdata(iobus_out),
      .csr(csr_v),
      .load(load_v),
      .count(count_v),
      .tc_evt(tc[k])
    );
  end
  // read mux: at most one source is nonzero for any address
  always_comb begin
    iobus_in = pend_hit ? 32'(pend_q) : '0;
    for (int k = 0; k < NUM_CH; k++) iobus_in = iobus_in | ch_rd[k];
  end
  // write-1-to-clear, with a same-cycle terminal event winning
  always_comb pend_d = (pend_q & ~((iobus_wr && pend_hit) ? iobus_out[NUM_CH-1:0] : '0)) | tc;
  // pending register
  always_ff @(posedge clk) pend_q <= RST ? '0 : pend_d;
  assign intr = |(pend_q & ie);
endmodule

// File: tb/tb_otter_timer_bank.sv
// tb_otter_timer_bank: directed checks of a 2-channel timer bank
module tb_otter_timer_bank;
  localparam logic [31:0] B = 32'h1100_D000;
  localparam logic [31:0] PEND = B + 32'h100;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, intr;
  logic [31:0] addr = '0, wdata = '0, rdata;
  int n = 0, fails = 0;
  otter_timer_bank #(.NUM_CH(2), .CNT_W(32), .BASE_ADDR(B)) dut (
    .clk(clk), .RST(rst), .iobus_addr(addr), .iobus_out(wdata), .iobus_wr(wr),
    .iobus_in(rdata), .intr(intr)
  );
  always #10 clk = ~clk;
  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask
  task automatic chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    n++;
    assert (rdata === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, rdata, exp);
    end
  endtask
  task automatic chk_intr(input logic exp, input string tag);
    n++;
    assert (intr === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, intr, exp);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk(B, 0, "rst_csr0");
    chk(B + 8, 0, "rst_cnt0");
    chk(PEND, 0, "rst_pend");
    chk_intr(0, "rst_intr");
    wr_reg(B + 4, 3);
    wr_reg(B, 32'h05);
    repeat (3) @(negedge clk);
    chk(PEND, 0, "per_e3");
    @(negedge clk);
    chk(PEND, 1, "per_e4");
    chk_intr(1, "per_intr_e4");
    wr_reg(PEND, 1);
    chk(PEND, 0, "per_clr");
    chk_intr(0, "per_intr_clr");
    @(negedge clk);
    chk(PEND, 0, "per_e7");
    @(negedge clk);
    chk(PEND, 1, "per_e8");
    wr_reg(PEND, 1);
    chk(PEND, 0, "per_clr2");
    wr_reg(PEND, 1);
    chk(PEND, 1, "w1c_vs_tick");
    wr_reg(B + 4, 5);
    chk(B + 8, 5, "load_vs_tick");
    wr_reg(B, 0);
    chk(B + 8, 4, "dis_freeze");
    repeat (3) @(negedge clk);
    chk(B + 8, 4, "dis_hold");
    wr_reg(PEND, 1);
    chk(PEND, 0, "pend_clr3");
    wr_reg(B + 32'h14, 1);
    wr_reg(B + 32'h10, 32'h0207);
    repeat (5) @(negedge clk);
    chk(PEND, 0, "os_e5");
    @(negedge clk);
    chk(PEND, 2, "os_e6");
    chk(B + 32'h10, 32'h0206, "os_csr");
    chk(B + 32'h18, 0, "os_cnt");
    chk_intr(1, "os_intr");
    wr_reg(PEND, 2);
    repeat (10) @(negedge clk);
    chk(PEND, 0, "os_no_more");
    chk(B + 32'h18, 0, "os_cnt_hold");
    chk(B + 32'h30, 0, "ch3_rd");
    wr_reg(B + 32'h30, 32'hFFFF);
    wr_reg(B + 32'h1FC, 32'hFFFF);
    wr_reg(B ^ 32'h1000_0000, 32'h5);
    wr_reg(B + 32'h1, 32'h5);
    chk(B + 32'h30, 0, "ch3_rd2");
    chk(B + 32'h1FC, 0, "hole_rd");
    chk(B, 0, "ch0_csr_untouched");
    chk(B + 4, 5, "ch0_load_untouched");
    chk(B + 32'h10, 32'h0206, "ch1_csr_untouched");
    wr_reg(B + 4, 0);
    wr_reg(B, 32'h01);
    repeat (2) @(negedge clk);
    chk(PEND, 1, "ie0_pend");
    chk_intr(0, "ie0_intr");
    wr_reg(B, 0);
    wr_reg(PEND, 1);
    chk(PEND, 0, "ie0_clr");
    wr_reg(B + 32'h14, 32'h1234);
    wr_reg(B + 32'h10, 32'hFF05);
    wr_reg(B, 32'h05);
    @(negedge clk);
    chk(B + 32'h18, 32'h1234, "pre_rst_cnt");
    chk_intr(1, "pre_rst_intr");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_intr(0, "post_rst_intr");
    chk(B, 0, "post_rst_csr0");
    chk(B + 4, 0, "post_rst_load0");
    chk(B + 32'h10, 0, "post_rst_csr1");
    chk(B + 32'h14, 0, "post_rst_load1");
    chk(B + 32'h18, 0, "post_rst_cnt1");
    chk(PEND, 0, "post_rst_pend");
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
